// File: rtl/gpio_pad_bank.sv
// GPIO bank controller for NPINS pad cells: output/enable registers, synchronised input,
// edge interrupts with W1C status. Define GPIO_DEBOUNCE_EN to add a per-pin input debounce filter.
module gpio_pad_bank #(
  parameter int unsigned NPINS           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPINS-1:0] pad_in,
  output logic [NPINS-1:0] pad_out,
  output logic [NPINS-1:0] pad_oe,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_addr,
  input  logic [NPINS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [NPINS-1:0] rsp_rdata,
  output logic             irq
);

  if (NPINS < 1 || NPINS > 32) begin : g_bad_npins
    $error("NPINS must be within 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e           state_q, state_d;
  logic [NPINS-1:0] out_q, out_d, oe_q, oe_d;
  logic [NPINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NPINS-1:0] status_q, status_d, prev_q, prev_d;
  logic [NPINS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_valid_q, rsp_valid_d, irq_q, irq_d;
  logic [NPINS-1:0] sync_q [SYNC_STAGES];
  logic [NPINS-1:0] sync_d [SYNC_STAGES];
  logic [NPINS-1:0] sync_in, filt_in, rd_data, w1c, edge_set;
  logic             accept;

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign req_ready = rst_n & (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign sync_in   = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = pad_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0]  cnt_q [NPINS];
  logic [CntW-1:0]  cnt_d [NPINS];
  logic [NPINS-1:0] sync_prev_q, sync_prev_d, filt_q, filt_d;

  // Counter restarts on any sync_in change; filt_in follows once the new value has held.
  always_comb begin
    sync_prev_d = sync_in;
    filt_d      = filt_q;
    for (int unsigned i = 0; i < NPINS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_in[i] != sync_prev_q[i]) begin
        cnt_d[i] = '0;
      end else if (sync_in[i] != filt_q[i] && cnt_q[i] != CntW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
      if (sync_in[i] != filt_q[i] && cnt_d[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d[i] = sync_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev_q <= '0;
      filt_q      <= '0;
      for (int unsigned i = 0; i < NPINS; i++) cnt_q[i] <= '0;
    end else begin
      sync_prev_q <= sync_prev_d;
      filt_q      <= filt_d;
      for (int unsigned i = 0; i < NPINS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt_in = filt_q;
`else
  assign filt_in = sync_in;
`endif

  always_comb begin
    case (req_addr)
      3'd0:    rd_data = out_q;
      3'd1:    rd_data = oe_q;
      3'd2:    rd_data = filt_in;
      3'd3:    rd_data = rise_en_q;
      3'd4:    rd_data = fall_en_q;
      3'd5:    rd_data = status_q;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    oe_d        = oe_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    w1c         = '0;
    rsp_valid_d = accept;
    rsp_rdata_d = '0;

    case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (req_write) begin
        case (req_addr)
          3'd0:    out_d     = req_wdata;
          3'd1:    oe_d      = req_wdata;
          3'd3:    rise_en_d = req_wdata;
          3'd4:    fall_en_d = req_wdata;
          3'd5:    w1c       = req_wdata;
          3'd6:    out_d     = out_q | req_wdata;
          3'd7:    out_d     = out_q & ~req_wdata;
          default: ;
        endcase
      end else begin
        rsp_rdata_d = rd_data;
      end
    end

    // A qualifying edge in the same cycle as a W1C keeps the bit set.
    edge_set = (filt_in & ~prev_q & rise_en_q) | (~filt_in & prev_q & fall_en_q);
    status_d = (status_q & ~w1c) | edge_set;
    prev_d   = filt_in;
    irq_d    = |(status_q & (rise_en_q | fall_en_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_q       <= '0;
      oe_q        <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      status_q    <= '0;
      prev_q      <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      status_q    <= status_d;
      prev_q      <= prev_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign pad_out   = out_q;
  assign pad_oe    = oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed self-checking bench for gpio_pad_bank (default build, NPINS=8, SYNC_STAGES=2).
module tb_gpio_pad_bank;

  localparam int unsigned NPINS = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NPINS-1:0] pad_in = '0;
  logic [NPINS-1:0] pad_out, pad_oe, rsp_rdata;
  logic             req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]       req_addr = '0;
  logic [NPINS-1:0] req_wdata = '0;
  logic             req_ready, rsp_valid, irq;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [NPINS-1:0] rd;

  gpio_pad_bank #(.NPINS(NPINS), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns two negedges later, back in idle.
  task automatic write_reg(input logic [2:0] a, input logic [NPINS-1:0] d);
    chk("wr_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
    @(negedge clk);
    chk("wr_rsp_end", 32'(rsp_valid), 32'h0);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [NPINS-1:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    d = rsp_rdata;
    @(negedge clk);
    chk("rd_rsp_end", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_pad_out", 32'(pad_out), 32'h0);
    chk("rst_pad_oe", 32'(pad_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h1);

    // OE / OUT writes and read-back
    write_reg(3'd1, 8'hFF);
    chk("pad_oe_ff", 32'(pad_oe), 32'hFF);
    write_reg(3'd0, 8'hA5);
    chk("pad_out_a5", 32'(pad_out), 32'hA5);
    read_reg(3'd0, rd);
    chk("rd_out_a5", 32'(rd), 32'hA5);

    // OUT_SET / OUT_CLR
    write_reg(3'd6, 8'h0A);
    chk("pad_out_set", 32'(pad_out), 32'hAF);
    write_reg(3'd7, 8'h81);
    chk("pad_out_clr", 32'(pad_out), 32'h2E);
    read_reg(3'd6, rd);
    chk("rd_out_set_zero", 32'(rd), 32'h0);
    read_reg(3'd7, rd);
    chk("rd_out_clr_zero", 32'(rd), 32'h0);
    write_reg(3'd2, 8'hFF);
    read_reg(3'd0, rd);
    chk("rd_out_after", 32'(rd), 32'h2E);

    // Rising edge on pin 0
    write_reg(3'd3, 8'h01);
    pad_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    chk("irq_before_status", 32'(irq), 32'h0);
    read_reg(3'd2, rd);
    chk("rd_in_bit0", 32'(rd), 32'h01);
    chk("irq_rise", 32'(irq), 32'h1);
    read_reg(3'd5, rd);
    chk("rd_status_rise", 32'(rd), 32'h01);
    write_reg(3'd5, 8'h01);
    chk("irq_cleared", 32'(irq), 32'h0);
    read_reg(3'd5, rd);
    chk("rd_status_cleared", 32'(rd), 32'h00);

    // Falling edge on pin 2 coinciding with W1C of the same bit
    write_reg(3'd3, 8'h05);
    write_reg(3'd4, 8'h04);
    pad_in = 8'h05;
    repeat (4) @(negedge clk);
    chk("irq_rise_pin2", 32'(irq), 32'h1);
    read_reg(3'd5, rd);
    chk("rd_status_pin2", 32'(rd), 32'h04);
    pad_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    write_reg(3'd5, 8'h04);
    chk("irq_set_wins", 32'(irq), 32'h1);
    read_reg(3'd5, rd);
    chk("rd_status_set_wins", 32'(rd), 32'h04);
    read_reg(3'd2, rd);
    chk("rd_in_after_fall", 32'(rd), 32'h01);
    write_reg(3'd5, 8'h04);
    chk("irq_w1c_pin2", 32'(irq), 32'h0);

    // Clearing enables masks irq but keeps STATUS
    pad_in = 8'h05;
    repeat (4) @(negedge clk);
    chk("irq_rise_again", 32'(irq), 32'h1);
    write_reg(3'd3, 8'h00);
    write_reg(3'd4, 8'h00);
    chk("irq_masked", 32'(irq), 32'h0);
    read_reg(3'd5, rd);
    chk("rd_status_kept", 32'(rd), 32'h04);

    // Reset right after a read is accepted
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("mid_rst_pad_out", 32'(pad_out), 32'h0);
    chk("mid_rst_pad_oe", 32'(pad_oe), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("mid_rst_rsp_hold", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'h1);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'h0);
    read_reg(3'd0, rd);
    chk("rd_out_after_rst", 32'(rd), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_pad_bank.md
Name: gpio_pad_bank

Overview:
- Parametrised GPIO bank controller driving the bidirectional PADINOUT cells of the padring; generalises the fixed 8-pin GPIO group to NPINS pins.
- Per-pin output data, output enable, input synchroniser, rising/falling edge interrupt with sticky status, and a simple valid/ready register port for the core.
- Sits between the core bus fabric and the pad cells; one instance per GPIO group.

Parameters:
- NPINS, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the filtered input changes (used only with GPIO_DEBOUNCE_EN; >=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pad_in  in  NPINS  raw pad input, asynchronous to clk.
- pad_out  out  NPINS  pad output data.
- pad_oe  out  NPINS  pad output enable, 1 = drive.
- req_valid  in  1  register request valid.
- req_ready  out  1  register request accepted when valid&ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  3  register index.
- req_wdata  in  NPINS  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  NPINS  read data, valid with rsp_valid; 0 for writes.
- irq  out  1  level interrupt, OR of (status & enables).

Behaviour:
- Reset (rst_n low, asynchronous): pad_out=0, pad_oe=0, all registers 0, synchroniser flops 0, rsp_valid=0, rsp_rdata=0, irq=0, req_ready=0 while reset is asserted.
- Register map: 0 OUT (rw); 1 OE (rw); 2 IN (ro, filtered input); 3 RISE_EN (rw); 4 FALL_EN (rw); 5 STATUS (read, write-1-to-clear); 6 OUT_SET (wo, OUT |= wdata, reads 0); 7 OUT_CLR (wo, OUT &= ~wdata, reads 0).
- Writes to address 2 are ignored.
- Handshake FSM: IDLE -> RESP on valid&ready; RESP -> IDLE unconditionally the next cycle.
- req_ready=1 in IDLE only, so one transaction per two cycles max.
- Register update takes effect on the accept edge; pad_out/pad_oe change that edge.
- rsp_valid is high exactly one cycle, the cycle after accept. There is no response backpressure.
- Read data is the register value sampled at the accept edge.
- Input path: pad_in passes through SYNC_STAGES flops to give sync_in. Without debounce, filt_in = sync_in.
- Total latency from pad_in change to IN-register visibility is SYNC_STAGES cycles.
- Edge detect: prev_in is filt_in delayed by one cycle.
  - rise = filt_in & ~prev_in; fall = ~filt_in & prev_in.
  - STATUS[i] sets when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
- STATUS sets one cycle after filt_in changes; irq is registered and rises the following cycle.
- Simultaneous W1C and new qualifying edge on the same bit in the same cycle: set wins, bit stays 1.
- Enables gate only new edges. Clearing an enable does not clear existing STATUS, but irq masks it.
- irq = |(STATUS & (RISE_EN|FALL_EN)), registered.
- Reset mid-transaction: pending response is dropped, and rsp_valid never asserts for that request.
- Address bits beyond 7 do not exist; bits above NPINS are ignored on write and read as 0.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined: each pin has a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever sync_in differs from its value one cycle earlier.
  - When sync_in != filt_in and the counter reaches DEBOUNCE_CYCLES-1, filt_in takes sync_in and the counter holds.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach IN/STATUS.
  - Added latency is DEBOUNCE_CYCLES cycles.
  - filt_in resets to 0.
- Not defined: no counters, filt_in = sync_in, and the DEBOUNCE_CYCLES parameter is unused.

Test Plan:
- Reset then write OE=0xFF, OUT=0xA5 -> pad_oe=0xFF and pad_out=0xA5 the cycle after accept; rsp_valid pulses once; read OUT returns 0xA5.
- OUT=0xA5, write OUT_SET=0x0A then OUT_CLR=0x81 -> pad_out goes 0xAF then 0x2E; reads of addresses 6/7 return 0.
- RISE_EN=0x01; drive pad_in[0] 0->1 -> IN[0]=1 after 2 cycles, STATUS=0x01 next cycle, irq=1 the cycle after; write STATUS=0x01 -> irq=0 two cycles later.
- FALL_EN=0x04, pad_in[2] 1->0 timed so the edge lands in the same cycle as a STATUS W1C of 0x04 -> STATUS[2] stays 1 and irq stays 1.
- Assert rst_n low in the cycle after accepting a read -> rsp_valid stays 0, all outputs 0 immediately; after release, req_ready=1.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 3-cycle pulse on pad_in[1] -> IN unchanged and no STATUS; a 6-cycle pulse -> IN[1]=1 after 2+4 cycles.
